// File: rtl/led_blink_sched_pkg.sv
// Shared types and constants for the LED blink scheduler.
package led_pkg;

  typedef enum logic [1:0] {
    LED_OFF   = 2'd0,
    LED_ON    = 2'd1,
    LED_BLINK = 2'd2,
    LED_PULSE = 2'd3
  } led_mode_t;

  // Cycles a channel stays quiet after a pulse, covering led_driver latency.
  localparam int HOLDOFF_CYC = 2;
  localparam int HOLDOFF_W   = $clog2(HOLDOFF_CYC + 1);

endpackage

// File: rtl/led_blink_sched_if.sv
// Config-write / feedback / pulse bundle between the glue logic and the scheduler.
interface led_blink_sched_if #(
  parameter int N_CH  = 4,
  parameter int PER_W = 12,
  parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
);

  logic                    wr_en;
  logic [CH_W-1:0]         wr_ch;
  led_pkg::led_mode_t      wr_mode;
  logic [PER_W-1:0]        wr_period;
  logic                    sync;
  logic [N_CH-1:0]         led_state;
  logic [N_CH-1:0]         en_out;
  logic                    tick;

  modport master (
    output wr_en, wr_ch, wr_mode, wr_period, sync, led_state,
    input  en_out, tick
  );

  modport slave (
    input  wr_en, wr_ch, wr_mode, wr_period, sync, led_state,
    output en_out, tick
  );

endinterface

// File: rtl/led_blink_sched_tick_gen.sv
// Prescaler producing a registered one-cycle tick every CLK_HZ/TICK_HZ cycles.
module tick_gen #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // A clear also drops any tick that the old phase would have produced.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (clr) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      tick  <= (count == LAST);
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/led_blink_sched.sv
// Multi-channel scheduler issuing toggle pulses to led_driver cells for
// OFF / ON / BLINK / PULSE patterns, closing the loop on driver feedback.
//
// state     | meaning
// LED_OFF   | pulse while feedback is 1, counter held at 0
// LED_ON    | pulse while feedback is 0, counter held at 0
// LED_BLINK | pulse once every period ticks, feedback ignored
// LED_PULSE | act as ON, drop to LED_OFF after period ticks
module led_blink_sched
  import led_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1000,
  parameter int PER_W   = 12
) (
  input logic            clk,
  input logic            rst,
  led_blink_sched_if.slave bus
);

  localparam logic [HOLDOFF_W-1:0] HOLD_LOAD = HOLDOFF_W'(HOLDOFF_CYC);

  logic            tick_i;
  logic [N_CH-1:0] en_vec;

  tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.sync),
    .tick (tick_i)
  );

  assign bus.tick   = tick_i;
  assign bus.en_out = en_vec;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    led_mode_t             mode;
    logic [PER_W-1:0]      period;
    logic [PER_W-1:0]      cnt;
    logic [HOLDOFF_W-1:0]  holdoff;
    logic                  en_q;
    logic                  wr_hit;
    logic                  free;
    logic                  led;
    logic [PER_W-1:0]      last_cnt;
    logic                  at_last;

    // Index compare naturally rejects wr_ch values beyond the channel count.
    assign wr_hit   = bus.wr_en && (int'(bus.wr_ch) == i);
    assign free     = (holdoff == '0);
    assign led      = bus.led_state[i];
    assign last_cnt = (period == '0) ? '0 : period - 1'b1;
    assign at_last  = (cnt >= last_cnt);
    assign en_vec[i] = en_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        mode    <= LED_OFF;
        period  <= '0;
        cnt     <= '0;
        holdoff <= '0;
        en_q    <= 1'b0;
      end else begin
        en_q    <= 1'b0;
        holdoff <= free ? '0 : holdoff - 1'b1;
        if (wr_hit) begin
          mode   <= bus.wr_mode;
          period <= bus.wr_period;
          cnt    <= '0;
        end else begin
          case (mode)
            LED_OFF: begin
              cnt <= '0;
              if (led && free) begin
                en_q    <= 1'b1;
                holdoff <= HOLD_LOAD;
              end
            end
            LED_ON: begin
              cnt <= '0;
              if (!led && free) begin
                en_q    <= 1'b1;
                holdoff <= HOLD_LOAD;
              end
            end
            LED_BLINK: begin
              if (bus.sync) begin
                cnt <= '0;
              end else if (tick_i) begin
                if (at_last) begin
                  cnt <= '0;
                  if (free) begin
                    en_q    <= 1'b1;
                    holdoff <= HOLD_LOAD;
                  end
                end else begin
                  cnt <= cnt + 1'b1;
                end
              end
            end
            LED_PULSE: begin
              if (!led && free) begin
                en_q    <= 1'b1;
                holdoff <= HOLD_LOAD;
              end
              if (bus.sync) begin
                cnt <= '0;
              end else if (tick_i) begin
                if (at_last) begin
                  mode <= LED_OFF;
                  cnt  <= '0;
                end else begin
                  cnt <= cnt + 1'b1;
                end
              end
            end
            default: begin
              mode <= LED_OFF;
              cnt  <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_led_blink_sched.sv
// Bench for led_blink_sched: four toggle drivers, a cycle-level pattern model and directed scenarios.
module tb_led_blink_sched;
  import led_pkg::*;

  localparam int N_CH  = 4;
  localparam int PER_W = 12;
  localparam int DIV   = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N_CH-1:0] led;

  int checks = 0;
  int errors = 0;

  led_blink_sched_if #(.N_CH(N_CH), .PER_W(PER_W)) bus ();

  led_blink_sched #(
    .N_CH    (N_CH),
    .CLK_HZ  (10),
    .TICK_HZ (1),
    .PER_W   (PER_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Four led_driver cells: toggle dout on each en pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) led <= '0;
    else      led <= led ^ bus.en_out;
  end
  assign bus.led_state = led;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Ticks come from cycle arithmetic relative to the last prescaler restart,
  // holdoff from the distance to the last pulse decision, and the LED copy
  // toggles one cycle after each expected pulse.
  int              cyc, anchor;
  int              m_last [N_CH];
  led_mode_t       m_mode [N_CH];
  int              m_per  [N_CH];
  int              m_cnt  [N_CH];
  logic [N_CH-1:0] en_e, led_e, m_nxt;
  logic            tick_e, m_tk, m_can;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        cyc = 0; anchor = 0; en_e = '0; led_e = '0; tick_e = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
          m_mode[i] = LED_OFF; m_per[i] = 1; m_cnt[i] = 0; m_last[i] = -100;
        end
      end else begin
        m_nxt = '0;
        m_tk  = tick_e && !bus.sync;
        for (int i = 0; i < N_CH; i++) begin
          m_can = (cyc - m_last[i]) > HOLDOFF_CYC;
          if (bus.wr_en && int'(bus.wr_ch) == i) begin
            m_mode[i] = bus.wr_mode;
            m_per[i]  = (bus.wr_period == '0) ? 1 : int'(bus.wr_period);
            m_cnt[i]  = 0;
          end else begin
            case (m_mode[i])
              LED_OFF: m_nxt[i] = led_e[i] && m_can;
              LED_ON:  m_nxt[i] = !led_e[i] && m_can;
              LED_BLINK: begin
                if (bus.sync) m_cnt[i] = 0;
                else if (m_tk) begin
                  m_cnt[i]++;
                  if (m_cnt[i] >= m_per[i]) begin
                    m_cnt[i] = 0;
                    m_nxt[i] = m_can;
                  end
                end
              end
              default: begin
                m_nxt[i] = !led_e[i] && m_can;
                if (bus.sync) m_cnt[i] = 0;
                else if (m_tk) begin
                  m_cnt[i]++;
                  if (m_cnt[i] >= m_per[i]) begin
                    m_cnt[i]  = 0;
                    m_mode[i] = LED_OFF;
                  end
                end
              end
            endcase
          end
          if (m_nxt[i]) m_last[i] = cyc;
        end
        led_e = led_e ^ en_e;
        en_e  = m_nxt;
        if (bus.sync) anchor = cyc + 1;
        cyc++;
        tick_e = (cyc > anchor) && (((cyc - anchor) % DIV) == 0);
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("model_en_out", int'(bus.en_out), int'(en_e));
        chk("model_tick",   int'(bus.tick),   int'(tick_e));
        chk("model_led",    int'(led),        int'(led_e));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wr(input int ch, input led_mode_t md, input int per);
    bus.wr_en     = 1'b1;
    bus.wr_ch     = 2'(ch);
    bus.wr_mode   = md;
    bus.wr_period = PER_W'(per);
    @(negedge clk);
    bus.wr_en     = 1'b0;
  endtask

  task automatic wait_tick(input string nm);
    int n;
    n = 0;
    while (!bus.tick && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.tick) chk({nm, "_timeout"}, 0, 1);
  endtask

  initial begin
    int n, cnt_a, cnt_b, mis;
    bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_mode = LED_OFF;
    bus.wr_period = '0; bus.sync = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_en_out", int'(bus.en_out), 0);
    chk("rst_tick",   int'(bus.tick),   0);
    chk("rst_led",    int'(led),        0);
    rst = 1'b1;

    n = 0;
    do begin @(negedge clk); n++; end while (!bus.tick && n < 40);
    chk("first_tick_cycle", n, 10);

    // BLINK ch0 period 3: one toggle every 30 cycles, other channels silent.
    wr(0, LED_BLINK, 3);
    n = 0;
    while (!bus.en_out[0] && n < 100) begin @(negedge clk); n++; end
    chk("blink0_first_seen", int'(bus.en_out[0]), 1);
    n = 0; cnt_b = 0;
    do begin
      @(negedge clk); n++;
      if (bus.en_out[3:1] != '0) cnt_b++;
    end while (!bus.en_out[0] && n < 100);
    chk("blink0_gap", n, 30);
    chk("blink0_others_quiet", cnt_b, 0);
    wr(0, LED_OFF, 0);
    repeat (10) @(negedge clk);
    chk("ch0_off_led", int'(led[0]), 0);

    // ON then OFF on ch1: exactly one pulse per transition.
    wr(1, LED_ON, 0);
    cnt_a = 0;
    for (int k = 0; k < 10; k++) begin @(negedge clk); cnt_a += int'(bus.en_out[1]); end
    chk("on1_pulses", cnt_a, 1);
    chk("on1_led", int'(led[1]), 1);
    wr(1, LED_OFF, 0);
    cnt_a = 0;
    for (int k = 0; k < 10; k++) begin @(negedge clk); cnt_a += int'(bus.en_out[1]); end
    chk("off1_pulses", cnt_a, 1);
    chk("off1_led", int'(led[1]), 0);

    // PULSE ch2 period 5: on within 3 cycles, off after five ticks, stays off.
    wr(2, LED_PULSE, 5);
    repeat (2) @(negedge clk);
    chk("pulse2_on", int'(led[2]), 1);
    n = 0;
    while (led[2] && n < 100) begin @(negedge clk); n++; end
    chk("pulse2_len_in_range", int'(n >= 40 && n <= 51), 1);
    repeat (30) @(negedge clk);
    chk("pulse2_stays_off", int'(led[2]), 0);

    // Write ch3 BLINK period 1 in a tick cycle: that tick is consumed, next one pulses.
    wait_tick("ch3_tick");
    wr(3, LED_BLINK, 1);
    cnt_a = int'(bus.en_out[3]);
    for (int k = 0; k < 9; k++) begin @(negedge clk); cnt_a += int'(bus.en_out[3]); end
    chk("wr_tick_no_pulse", cnt_a, 0);
    @(negedge clk);
    chk("wr_tick_next_pulse", int'(bus.en_out[3]), 1);
    wr(3, LED_OFF, 0);
    repeat (10) @(negedge clk);

    // Two BLINK channels at different phases, then realign with sync.
    wr(0, LED_BLINK, 2);
    wait_tick("phase_tick");
    repeat (2) @(negedge clk);
    wr(1, LED_BLINK, 2);
    mis = 0;
    for (int k = 0; k < 60; k++) begin @(negedge clk); if (bus.en_out[0] != bus.en_out[1]) mis++; end
    chk("pre_sync_misaligned", int'(mis > 0), 1);
    bus.sync = 1'b1;
    @(negedge clk);
    bus.sync = 1'b0;
    mis = 0; cnt_a = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.en_out[0] != bus.en_out[1]) mis++;
      cnt_a += int'(bus.en_out[0]);
    end
    chk("post_sync_misaligned", mis, 0);
    chk("post_sync_pulses", cnt_a, 2);

    // Asynchronous reset while a pulse is on the output.
    n = 0;
    while (bus.en_out == '0 && n < 40) begin @(negedge clk); n++; end
    chk("pre_reset_pulse_seen", int'(bus.en_out != '0), 1);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_en_out", int'(bus.en_out), 0);
    chk("async_rst_tick", int'(bus.tick), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_quiet", int'(bus.en_out), 0);
    chk("post_rst_led", int'(led), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
